// File: rtl/pwm_seq_ctrl_if.sv
// pwm_seq_ctrl_if: write bus into the sequence FIFO of pwm_seq_ctrl.
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master FIFO can accept (not full)
//   wr_data   master -> slave  compare set, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
interface pwm_seq_ctrl_if #(
  parameter int CHN_NUM    = 4,
  parameter int DATA_WIDTH = 16
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [CHN_NUM*DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: duty-cycle sequencer in front of the 4-channel PWM core.
// Software queues compare sets in a FIFO; each set is applied and held for
// (rpt_i+1) PWM periods, advancing at the period boundary. A sticky interrupt
// flags sequence completion or a low FIFO level so software can refill.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           run enable (level)
//   flush_i        empty the FIFO (pulse), wins over a same-cycle write
//   rpt_i          extra periods per entry, captured when an entry loads
//   wr_bus         FIFO write handshake (slave side)
//   period_end_i   PWM counter wrap pulse
//   cmp_o          active compare set; cmp_upd_o pulses when it changes
//   level_o        FIFO occupancy
//   busy_o         sequencer running
//   irq_clr_i      clear sticky flags (pulse)
//   irq_o          done_flag | lwm_flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not sequencing; loads the FIFO head as soon as en_i and data
// RUN   | holding cmp_o, counting periods, advancing at period ends
module pwm_seq_ctrl #(
  parameter int CHN_NUM    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LWM        = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               flush_i,
  input  logic [7:0]                         rpt_i,
  pwm_seq_ctrl_if.slave                      wr_bus,
  input  logic                               period_end_i,
  output logic [CHN_NUM*DATA_WIDTH-1:0]      cmp_o,
  output logic                               cmp_upd_o,
  output logic [$clog2(FIFO_DEPTH):0]        level_o,
  output logic                               busy_o,
  input  logic                               irq_clr_i,
  output logic                               irq_o
);

  localparam int CMP_W = CHN_NUM * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  logic [CMP_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;

  state_t           state_q, state_d;
  logic [7:0]       rep_q, rep_d;
  logic [CMP_W-1:0] cmp_q, cmp_d;
  logic             upd_q, upd_d;
  logic             done_q, done_d;
  logic             lwm_q, lwm_d;

  logic             wr_fire;
  logic             pop;
  logic             done_set;
  logic             lwm_set;
  logic             fifo_full;
  logic             fifo_empty;

  assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign wr_fire    = wr_bus.wr_valid & ~fifo_full & ~flush_i;

  // The FSM decides on count_q, so a write landing in the same cycle as a
  // pop from an empty FIFO is not seen until the following cycle.
  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    cmp_d    = cmp_q;
    upd_d    = 1'b0;
    pop      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && !fifo_empty) begin
          pop     = 1'b1;
          cmp_d   = mem_q[rd_ptr_q];
          upd_d   = 1'b1;
          rep_d   = rpt_i;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          rep_d   = '0;
          state_d = ST_IDLE;
        end else if (period_end_i) begin
          if (rep_q != '0) begin
            rep_d = rep_q - 8'd1;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            cmp_d = mem_q[rd_ptr_q];
            upd_d = 1'b1;
            rep_d = rpt_i;
          end else begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(wr_fire) - LVL_W'(pop);
    end
  end

  // Low-watermark only counts pops made while already running.
  assign lwm_set = pop && (state_q == ST_RUN) && (count_d <= LVL_W'(LWM));

  // A set event beats a simultaneous clear.
  assign done_d = done_set | (done_q & ~irq_clr_i);
  assign lwm_d  = lwm_set  | (lwm_q  & ~irq_clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rep_q    <= '0;
      cmp_q    <= '0;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      lwm_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      cmp_q    <= cmp_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      lwm_q    <= lwm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy tracking alone defines valid entries.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_bus.wr_data;
  end

  assign wr_bus.wr_ready = ~fifo_full;
  assign cmp_o           = cmp_q;
  assign cmp_upd_o       = upd_q;
  assign level_o         = count_q;
  assign busy_o          = (state_q == ST_RUN);
  assign irq_o           = done_q | lwm_q;

endmodule
